temporal_buffer_ctrl: RTL and testbench
=======================================

Name: temporal_buffer_ctrl

Overview:
Sequencing controller for the Temporal_Buffer storage array. It turns that buffer into an in-order queue between the clause-fetch stage (producer) and the break-value stage (consumer), using valid/ready handshakes on both sides.
- Buffer slots 0..NSAT-2 hold queued literal groups.
- Index NSAT-1 is the buffer's combinational bypass. The controller selects it for cut-through when the queue is empty.
- The controller owns all write-index, write-enable and read-index generation for the buffer.

Parameters:
- NSAT, 3, clause width; must be >= 2. Storage depth DEPTH = NSAT-1; bypass index = NSAT-1.
- LAW, 12, literal address width.
- SIZE, 2, literals per stored group (NSAT-1). DATA_WIDTH = SIZE*LAW.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-low.
- flush_i  in  1  synchronous queue clear (active-high).
- in_valid_i  in  1  producer has a literal group.
- in_ready_o  out  1  controller accepts the group this cycle.
- in_literals_i  in  DATA_WIDTH  producer literal group.
- out_valid_o  out  1  consumer-side group available.
- out_ready_i  in  1  consumer takes the group this cycle.
- out_literals_o  out  DATA_WIDTH  group to consumer; wired from buf_literals_i.
- buf_wr_index_o  out  NSAT_BITS  buffer write index.
- buf_wr_en_o  out  1  buffer write enable.
- buf_wr_literals_o  out  DATA_WIDTH  buffer write data; equals in_literals_i.
- buf_rd_index_o  out  NSAT_BITS  buffer read index.
- buf_literals_i  in  DATA_WIDTH  buffer read data; combinational read, same cycle.
- occupancy_o  out  NSAT_BITS  registered count of stored groups, 0..DEPTH.

NSAT_BITS = $clog2(NSAT).

Behaviour:
- State: wr_ptr and rd_ptr, each 0..DEPTH-1, wrapping DEPTH-1 -> 0; count, 0..DEPTH. All registered.
- Reset (rst_i=0 at posedge): wr_ptr=rd_ptr=count=0.
  - While rst_i=0: in_ready_o=0, out_valid_o=0, buf_wr_en_o=0, occupancy_o=0.
  - buf_rd_index_o = NSAT-1; buf_wr_index_o = 0.
- Flush (flush_i=1, rst_i=1): at the next posedge, same clears as reset.
  - During the flush cycle: in_ready_o=0, out_valid_o=0, buf_wr_en_o=0, and no pop occurs.
  - Buffer contents are not cleared; they are stale but unreachable.
- Combinational outputs, outside reset/flush:
  - in_ready_o = (count < DEPTH).
  - bypass = (count==0) & in_valid_i.
  - out_valid_o = (count>0) | in_valid_i.
  - buf_rd_index_o = (count>0) ? rd_ptr : NSAT-1.
  - push = in_valid_i & in_ready_o & ~(bypass & out_ready_i).
  - pop = (count>0) & out_ready_i.
  - buf_wr_en_o = push; buf_wr_index_o = wr_ptr.
- Cut-through, zero latency:
  - When count==0 and in_valid_i=1, the consumer sees in_literals_i via the bypass index in the same cycle.
  - If out_ready_i=1, the group is consumed and nothing is stored.
  - If out_ready_i=0, the group is written to slot wr_ptr and count becomes 1.
- Stored path: data written at edge N is readable from cycle N+1 onward. Minimum storage latency is 1 cycle.
- Simultaneous push and pop with count>0: both pointers advance, count is unchanged, FIFO order is preserved.
- Full (count==DEPTH): in_ready_o=0 even if out_ready_i=1. There is no same-cycle refill; the freed slot is accepted on the next cycle.
- Empty with in_valid_i=0: out_valid_o=0; buf_rd_index_o holds NSAT-1.
- Stall stability: while out_valid_o=1 and out_ready_i=0, buf_rd_index_o and out_literals_o must not change.
  - Exception: in bypass mode, out_literals_o follows the producer. The producer must hold its data while valid.
- Pointer wrap: when DEPTH=1, pointers remain 0.
- Invariant: the write index never equals an unread stored slot while count>0. Assert this in the bench.

Decomposition:
- Shared package temporal_buffer_pkg holds:
  - NSAT, LAW, SIZE defaults;
  - derived DATA_WIDTH, NSAT_BITS, DEPTH, BYPASS_IDX = NSAT-1;
  - a ptr_inc(ptr) wrap function.
- Controller logic is flat.
- One natural sub-module: temporal_buffer_queue, a wrapper instantiating temporal_buffer_ctrl plus Temporal_Buffer. Its reset adapter drives the buffer's active-high reset from ~rst_i.

Test Plan:
- Reset: hold rst_i=0 for 2 cycles -> in_ready_o=0, out_valid_o=0, occupancy_o=0, buf_rd_index_o=2. After release -> in_ready_o=1.
- Cut-through: count=0, in_valid=1, data 24'hABCDEF, out_ready=1 -> out_valid_o=1, out_literals_o=ABCDEF same cycle, buf_wr_en_o=0, occupancy stays 0.
- Fill/full: out_ready=0; push 24'h111111 and 24'h222222 -> writes go to idx 0 then 1, occupancy=2, in_ready_o=0. A third push is held and not written.
- Drain order with wrap: out_ready=1 from full -> outputs 111111 (rd idx 0) then 222222 (rd idx 1). Then push 24'h333333 with out_ready=0 -> written to idx 0 (wrap), read back at idx 0.
- Simultaneous push and pop at count=1 (head 24'h444444, new 24'h555555) -> 444444 consumed, 555555 written, occupancy stays 1, next output 555555.
- Flush mid-stream: occupancy=2, flush_i=1 for one cycle -> that cycle out_valid_o=0 and in_ready_o=0. Next cycle occupancy=0, buf_rd_index_o=2, and the next input takes the bypass path.

Source files
------------

// File: rtl/temporal_buffer_pkg.sv
// ---------------------------------------------------------------------------
// temporal_buffer_pkg
// Shared sizing constants for the Temporal_Buffer sequencing slice.
//   NSAT        clause width; slots 0..NSAT-2 store groups, NSAT-1 is bypass
//   LAW         literal address width
//   SIZE        literals per stored group
//   DATA_WIDTH  bits per literal group (SIZE*LAW)
//   NSAT_BITS   width of buffer indices and occupancy
//   DEPTH       number of storage slots
//   BYPASS_IDX  buffer index that reads the write data combinationally
// ptr_inc() advances a slot pointer with wrap at the storage depth.
// ---------------------------------------------------------------------------
package temporal_buffer_pkg;

    localparam int NSAT       = 3;
    localparam int LAW        = 12;
    localparam int SIZE       = NSAT - 1;
    localparam int DATA_WIDTH = SIZE * LAW;
    localparam int NSAT_BITS  = $clog2(NSAT);
    localparam int DEPTH      = NSAT - 1;
    localparam int BYPASS_IDX = NSAT - 1;

    // Next slot after ptr, wrapping from depth-1 back to 0; with a single
    // slot the pointer never leaves 0.
    function automatic int ptr_inc(input int ptr, input int depth);
        if (ptr + 1 >= depth) begin
            return 0;
        end
        return ptr + 1;
    endfunction

endpackage

// File: rtl/temporal_buffer_queue.sv
// ---------------------------------------------------------------------------
// Temporal_Buffer
// Literal-group storage array with a combinational read port.
//   clock, reset        clock and asynchronous active-high reset
//   wr_index/wr_en      slot written at the clock edge with wr_literals
//   rd_index            read index; NSAT-1 returns wr_literals (bypass)
//   rd_literals         combinational read data
//
// temporal_buffer_queue
// In-order queue built from temporal_buffer_ctrl plus Temporal_Buffer.
//   clk_i, rst_i        clock, synchronous active-low reset
//   flush_i             synchronous queue clear
//   in_valid_i/in_ready_o/in_literals_i      producer handshake and data
//   out_valid_o/out_ready_i/out_literals_o   consumer handshake and data
//   occupancy_o         number of stored groups
// ---------------------------------------------------------------------------
module Temporal_Buffer #(
    parameter int NSAT       = 3,
    parameter int DATA_WIDTH = 24
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [$clog2(NSAT)-1:0]  wr_index,
    input  logic                     wr_en,
    input  logic [DATA_WIDTH-1:0]    wr_literals,
    input  logic [$clog2(NSAT)-1:0]  rd_index,
    output logic [DATA_WIDTH-1:0]    rd_literals
);

    localparam int IW    = $clog2(NSAT);
    localparam int SLOTS = NSAT - 1;

    logic [DATA_WIDTH-1:0] r_mem [SLOTS];

    // Storage slots; only the addressed slot is updated on a write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SLOTS; k++) begin
                r_mem[k] <= '0;
            end
        end else if (wr_en) begin
            for (int k = 0; k < SLOTS; k++) begin
                if (wr_index == IW'(k)) begin
                    r_mem[k] <= wr_literals;
                end
            end
        end
    end

    // Read port: the top index passes the write data straight through so an
    // empty queue can forward a group in the cycle it arrives.
    always_comb begin
        rd_literals = '0;
        if (rd_index == IW'(NSAT - 1)) begin
            rd_literals = wr_literals;
        end else begin
            for (int k = 0; k < SLOTS; k++) begin
                if (rd_index == IW'(k)) begin
                    rd_literals = r_mem[k];
                end
            end
        end
    end

endmodule

module temporal_buffer_queue import temporal_buffer_pkg::*; #(
    parameter int NSAT = temporal_buffer_pkg::NSAT,
    parameter int LAW  = temporal_buffer_pkg::LAW,
    parameter int SIZE = NSAT - 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [SIZE*LAW-1:0]       in_literals_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [SIZE*LAW-1:0]       out_literals_o,
    output logic [$clog2(NSAT)-1:0]   occupancy_o
);

    localparam int DW = SIZE * LAW;
    localparam int IW = $clog2(NSAT);

    logic [IW-1:0] w_wrIndex;
    logic          w_wrEn;
    logic [DW-1:0] w_wrLiterals;
    logic [IW-1:0] w_rdIndex;
    logic [DW-1:0] w_rdLiterals;
    logic          w_bufReset;

    // The storage array expects an active-high reset.
    assign w_bufReset = ~rst_i;

    temporal_buffer_ctrl #(
        .NSAT (NSAT),
        .LAW  (LAW),
        .SIZE (SIZE)
    ) u_ctrl (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .flush_i           (flush_i),
        .in_valid_i        (in_valid_i),
        .in_ready_o        (in_ready_o),
        .in_literals_i     (in_literals_i),
        .out_valid_o       (out_valid_o),
        .out_ready_i       (out_ready_i),
        .out_literals_o    (out_literals_o),
        .buf_wr_index_o    (w_wrIndex),
        .buf_wr_en_o       (w_wrEn),
        .buf_wr_literals_o (w_wrLiterals),
        .buf_rd_index_o    (w_rdIndex),
        .buf_literals_i    (w_rdLiterals),
        .occupancy_o       (occupancy_o)
    );

    Temporal_Buffer #(
        .NSAT       (NSAT),
        .DATA_WIDTH (DW)
    ) u_buffer (
        .clock       (clk_i),
        .reset       (w_bufReset),
        .wr_index    (w_wrIndex),
        .wr_en       (w_wrEn),
        .wr_literals (w_wrLiterals),
        .rd_index    (w_rdIndex),
        .rd_literals (w_rdLiterals)
    );

endmodule

// File: rtl/temporal_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// temporal_buffer_ctrl
// Sequences the Temporal_Buffer array as an in-order queue between the
// clause-fetch producer and the break-value consumer, with zero-latency
// cut-through through the bypass index when nothing is stored.
//   clk_i, rst_i        clock, synchronous active-low reset
//   flush_i             synchronous queue clear (active-high)
//   in_valid_i/in_ready_o/in_literals_i      producer handshake and data
//   out_valid_o/out_ready_i/out_literals_o   consumer handshake and data
//   buf_wr_index_o/buf_wr_en_o/buf_wr_literals_o  buffer write port
//   buf_rd_index_o/buf_literals_i                 buffer read port
//   occupancy_o         registered count of stored groups
// ---------------------------------------------------------------------------
module temporal_buffer_ctrl import temporal_buffer_pkg::*; #(
    parameter int NSAT = temporal_buffer_pkg::NSAT,
    parameter int LAW  = temporal_buffer_pkg::LAW,
    parameter int SIZE = NSAT - 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [SIZE*LAW-1:0]       in_literals_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [SIZE*LAW-1:0]       out_literals_o,
    output logic [$clog2(NSAT)-1:0]   buf_wr_index_o,
    output logic                      buf_wr_en_o,
    output logic [SIZE*LAW-1:0]       buf_wr_literals_o,
    output logic [$clog2(NSAT)-1:0]   buf_rd_index_o,
    input  logic [SIZE*LAW-1:0]       buf_literals_i,
    output logic [$clog2(NSAT)-1:0]   occupancy_o
);

    localparam int IW        = $clog2(NSAT);
    localparam int SLOTS     = NSAT - 1;
    localparam int PTR_W     = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [IW-1:0] FULL_CNT = IW'(SLOTS);
    localparam logic [IW-1:0] BYP_IDX  = IW'(NSAT - 1);

    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [IW-1:0]    r_count;

    logic w_active;
    logic w_notEmpty;
    logic w_bypass;
    logic w_push;
    logic w_pop;

    // Handshake and buffer control. Reset and flush both silence the
    // handshakes so nothing is accepted or consumed in those cycles. A group
    // arriving at an empty queue that the consumer takes at once never
    // touches storage.
    always_comb begin
        w_active   = rst_i & ~flush_i;
        w_notEmpty = (r_count != '0);
        w_bypass   = ~w_notEmpty & in_valid_i;

        in_ready_o  = w_active & (r_count < FULL_CNT);
        out_valid_o = w_active & (w_notEmpty | in_valid_i);

        w_push = in_valid_i & in_ready_o & ~(w_bypass & out_ready_i);
        w_pop  = w_active & w_notEmpty & out_ready_i;

        buf_wr_en_o       = w_push;
        buf_wr_literals_o = in_literals_i;
        buf_wr_index_o    = rst_i ? IW'(r_wrPtr) : '0;
        buf_rd_index_o    = (rst_i && w_notEmpty) ? IW'(r_rdPtr) : BYP_IDX;

        out_literals_o = buf_literals_i;
        occupancy_o    = rst_i ? r_count : '0;
    end

    // Queue state. A simultaneous push and pop moves both pointers and
    // leaves the count alone, which keeps the write slot clear of the head.
    always_ff @(posedge clk_i) begin
        if (!rst_i || flush_i) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= PTR_W'(ptr_inc(int'(r_wrPtr), SLOTS));
            end
            if (w_pop) begin
                r_rdPtr <= PTR_W'(ptr_inc(int'(r_rdPtr), SLOTS));
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_temporal_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_temporal_buffer_ctrl
// Drives temporal_buffer_ctrl with a behavioural stand-in for the storage
// array and checks every cycle against a queue-based model of the expected
// in-order behaviour, plus directed literal expectations.
// ---------------------------------------------------------------------------
module tb_temporal_buffer_ctrl;

    localparam int NSAT  = 3;
    localparam int DW    = 24;
    localparam int SLOTS = NSAT - 1;

    typedef struct {
        logic [DW-1:0] data;
        int            slot;
    } entry_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          inValid;
    logic          inReady;
    logic [DW-1:0] inLiterals;
    logic          outValid;
    logic          outReady;
    logic [DW-1:0] outLiterals;
    logic [1:0]    bufWrIndex;
    logic          bufWrEn;
    logic [DW-1:0] bufWrLiterals;
    logic [1:0]    bufRdIndex;
    logic [DW-1:0] bufLiterals;
    logic [1:0]    occupancy;

    logic [DW-1:0] mem [0:3];

    entry_t        modelQ[$];
    int            vectors    = 0;
    int            miscompares = 0;

    logic          pendClear;
    logic          pendPop;
    logic          pendPush;
    int            pendSlot;
    logic [DW-1:0] pendData;
    logic          pendWrite;
    logic [1:0]    pendWrIdx;
    logic [DW-1:0] pendWrData;

    always #5 clk = ~clk;

    // Storage array stand-in: bypass index returns the producer data.
    assign bufLiterals = (bufRdIndex == 2'd2) ? inLiterals : mem[bufRdIndex];

    temporal_buffer_ctrl dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .flush_i           (flush),
        .in_valid_i        (inValid),
        .in_ready_o        (inReady),
        .in_literals_i     (inLiterals),
        .out_valid_o       (outValid),
        .out_ready_i       (outReady),
        .out_literals_o    (outLiterals),
        .buf_wr_index_o    (bufWrIndex),
        .buf_wr_en_o       (bufWrEn),
        .buf_wr_literals_o (bufWrLiterals),
        .buf_rd_index_o    (bufRdIndex),
        .buf_literals_i    (bufLiterals),
        .occupancy_o       (occupancy)
    );

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare all outputs with the queue model and record what the coming
    // edge should do to the model and to the storage stand-in.
    task automatic checkOutput();
        int            sz;
        logic          expReady;
        logic          expValid;
        logic          clash;
        sz         = modelQ.size();
        pendClear  = 1'b0;
        pendPop    = 1'b0;
        pendPush   = 1'b0;
        pendWrite  = bufWrEn;
        pendWrIdx  = bufWrIndex;
        pendWrData = bufWrLiterals;
        if (!rst) begin
            checkVal("rst_in_ready", 32'(inReady), 0);
            checkVal("rst_out_valid", 32'(outValid), 0);
            checkVal("rst_wr_en", 32'(bufWrEn), 0);
            checkVal("rst_occupancy", 32'(occupancy), 0);
            checkVal("rst_rd_index", 32'(bufRdIndex), 2);
            checkVal("rst_wr_index", 32'(bufWrIndex), 0);
            pendClear = 1'b1;
        end else if (flush) begin
            checkVal("flush_in_ready", 32'(inReady), 0);
            checkVal("flush_out_valid", 32'(outValid), 0);
            checkVal("flush_wr_en", 32'(bufWrEn), 0);
            checkVal("flush_occupancy", 32'(occupancy), 32'(sz));
            pendClear = 1'b1;
        end else begin
            expReady = (sz < SLOTS);
            expValid = (sz > 0) || inValid;
            pendPop  = (sz > 0) && outReady;
            pendPush = inValid && expReady && !(sz == 0 && outReady);
            checkVal("occupancy", 32'(occupancy), 32'(sz));
            checkVal("in_ready", 32'(inReady), 32'(expReady));
            checkVal("out_valid", 32'(outValid), 32'(expValid));
            checkVal("wr_en", 32'(bufWrEn), 32'(pendPush));
            if (expValid) begin
                checkVal("out_literals", 32'(outLiterals), (sz > 0) ? 32'(modelQ[0].data) : 32'(inLiterals));
            end
            checkVal("rd_index", 32'(bufRdIndex), (sz > 0) ? 32'(modelQ[0].slot) : 32'd2);
            if (bufWrEn) begin
                checkVal("wr_literals", 32'(bufWrLiterals), 32'(inLiterals));
                clash = (int'(bufWrIndex) >= SLOTS);
                foreach (modelQ[k]) begin
                    if (modelQ[k].slot == int'(bufWrIndex)) begin
                        clash = 1'b1;
                    end
                end
                vectors++;
                assert (!clash) else begin
                    miscompares++;
                    $display("[TB] FAIL wr_slot_free: write index %0d hits an unread slot at %0t", bufWrIndex, $time);
                end
            end
            pendSlot = int'(bufWrIndex);
            pendData = inLiterals;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic f, input logic iv,
                                 input logic [DW-1:0] lits, input logic ordy);
        rst        = r;
        flush      = f;
        inValid    = iv;
        inLiterals = lits;
        outReady   = ordy;
        #2;
        checkOutput();
    endtask

    task automatic advance();
        @(posedge clk);
        if (pendWrite) begin
            mem[pendWrIdx] = pendWrData;
        end
        if (pendClear) begin
            modelQ.delete();
        end else begin
            if (pendPop) begin
                void'(modelQ.pop_front());
            end
            if (pendPush) begin
                modelQ.push_back('{data: pendData, slot: pendSlot});
            end
        end
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            mem[k] = '0;
        end
        rst = 1'b0; flush = 1'b0; inValid = 1'b0; inLiterals = '0; outReady = 1'b0;
        @(negedge clk);

        // Reset held two cycles, then released.
        applyStimulus(0, 0, 0, 24'h0, 0); advance();
        applyStimulus(0, 0, 1, 24'h123456, 1);
        checkVal("lit_rst_rd_index", 32'(bufRdIndex), 2);
        advance();
        applyStimulus(1, 0, 0, 24'h0, 0);
        checkVal("lit_release_ready", 32'(inReady), 1);

        // Cut-through.
        applyStimulus(1, 0, 1, 24'hABCDEF, 1);
        checkVal("lit_ct_valid", 32'(outValid), 1);
        checkVal("lit_ct_data", 32'(outLiterals), 32'h00ABCDEF);
        checkVal("lit_ct_wr_en", 32'(bufWrEn), 0);
        advance();

        // Fill to full, third push held.
        applyStimulus(1, 0, 1, 24'h111111, 0);
        checkVal("lit_ct_occ", 32'(occupancy), 0);
        checkVal("lit_fill0_idx", 32'(bufWrIndex), 0);
        advance();
        applyStimulus(1, 0, 1, 24'h222222, 0);
        checkVal("lit_fill1_idx", 32'(bufWrIndex), 1);
        checkVal("lit_fill1_en", 32'(bufWrEn), 1);
        advance();
        applyStimulus(1, 0, 1, 24'h999999, 0);
        checkVal("lit_full_occ", 32'(occupancy), 2);
        checkVal("lit_full_ready", 32'(inReady), 0);
        checkVal("lit_full_wr_en", 32'(bufWrEn), 0);
        advance();

        // Drain in order, then push with wrap to slot 0.
        applyStimulus(1, 0, 0, 24'h0, 1);
        checkVal("lit_drain0", 32'(outLiterals), 32'h00111111);
        checkVal("lit_drain0_idx", 32'(bufRdIndex), 0);
        checkVal("lit_full_no_refill", 32'(inReady), 0);
        advance();
        applyStimulus(1, 0, 0, 24'h0, 1);
        checkVal("lit_drain1", 32'(outLiterals), 32'h00222222);
        checkVal("lit_drain1_idx", 32'(bufRdIndex), 1);
        advance();
        applyStimulus(1, 0, 1, 24'h333333, 0);
        checkVal("lit_wrap_idx", 32'(bufWrIndex), 0);
        advance();
        applyStimulus(1, 0, 0, 24'h0, 0);
        checkVal("lit_wrap_rd", 32'(bufRdIndex), 0);
        checkVal("lit_wrap_data", 32'(outLiterals), 32'h00333333);
        advance();

        // Simultaneous push and pop at count 1.
        applyStimulus(1, 0, 0, 24'h0, 1); advance();
        applyStimulus(1, 0, 1, 24'h444444, 0); advance();
        applyStimulus(1, 0, 1, 24'h555555, 1);
        checkVal("lit_pp_out", 32'(outLiterals), 32'h00444444);
        checkVal("lit_pp_wr_en", 32'(bufWrEn), 1);
        advance();
        applyStimulus(1, 0, 0, 24'h0, 0);
        checkVal("lit_pp_occ", 32'(occupancy), 1);
        checkVal("lit_pp_next", 32'(outLiterals), 32'h00555555);
        advance();

        // Flush mid-stream at occupancy 2.
        applyStimulus(1, 0, 1, 24'h666666, 0); advance();
        applyStimulus(1, 1, 1, 24'h888888, 1);
        checkVal("lit_flush_valid", 32'(outValid), 0);
        checkVal("lit_flush_ready", 32'(inReady), 0);
        advance();
        applyStimulus(1, 0, 1, 24'h777777, 1);
        checkVal("lit_postflush_occ", 32'(occupancy), 0);
        checkVal("lit_postflush_rd", 32'(bufRdIndex), 2);
        checkVal("lit_postflush_data", 32'(outLiterals), 32'h00777777);
        advance();

        // Randomized traffic against the queue model.
        for (int n = 0; n < 3000; n++) begin
            applyStimulus(($urandom_range(99) != 0),
                          ($urandom_range(99) < 3),
                          ($urandom_range(99) < 60),
                          DW'($urandom),
                          ($urandom_range(99) < 50));
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
